// File: rtl/micro_sequencer.sv
// micro_sequencer: next-address engine of the microprogrammed control unit.
//
// Computes the next microstore address from the current control word, the
// decoded instruction entry point and the status vector. It also handles
// MOC (memory-complete) waits and a single-level subroutine link register.
//
// Optional feature: define MSEQ_MOC_TIMEOUT_EN to enable the MOC watchdog.
// When the watchdog fires, the sequencer jumps to FAULT_STATE and sets the
// sticky mem_fault flag.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   rom_word   [63:0] control word for the current state (ROM output)
//   ir_entry   [7:0]  first microstate of the decoded instruction
//   cond       [7:0]  status vector, selected by the S field
//   moc        memory operation complete
//   state      [7:0]  current microstate; this is the ROM address
//   link_q     [7:0]  subroutine return address
//   mem_wait   combinational; high while the state is held waiting for MOC
//   mem_fault  sticky watchdog timeout flag (tied 0 without the feature)
module micro_sequencer #(
  parameter logic [7:0]  RESET_STATE = 8'd0,
  parameter logic [7:0]  FAULT_STATE = 8'd255,
  parameter int unsigned TIMEOUT     = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] rom_word,
  input  logic [7:0]  ir_entry,
  input  logic [7:0]  cond,
  input  logic        moc,
  output logic [7:0]  state,
  output logic [7:0]  link_q,
  output logic        mem_wait,
  output logic        mem_fault
);

  typedef struct packed {
    logic [2:0] n;
    logic       inv;
    logic       mi;
    logic [2:0] s;
    logic       lnk;
    logic [7:0] tgt;
  } uctl_t;

  uctl_t      uc;
  logic       c, held, sel_tgt, timeout;
  logic [7:0] inc, nxt;

  assign uc = '{n: rom_word[57:55], inv: rom_word[54], mi: rom_word[53],
                s: rom_word[52:50], lnk: rom_word[49], tgt: rom_word[41:34]};

  // Bits of the control word that belong to other blocks.
  logic unused_rom;
  assign unused_rom = ^{rom_word[63:58], rom_word[48:42], rom_word[33:0]};

  assign inc      = state + 8'd1;        // 8-bit, wraps 255 -> 0
  assign c        = cond[uc.s] ^ uc.inv;
  assign held     = uc.mi & ~moc;
  assign mem_wait = held;

  // sel_tgt marks the cases where TGT was chosen, which is what arms the link.
  always_comb begin
    nxt     = inc;
    sel_tgt = 1'b0;
    case (uc.n)
      3'b000: nxt = ir_entry;
      3'b001: nxt = RESET_STATE;
      3'b010: nxt = inc;
      3'b011: begin nxt = uc.tgt; sel_tgt = 1'b1; end
      3'b100: if (c) begin nxt = uc.tgt; sel_tgt = 1'b1; end
              else nxt = inc;
      3'b101: if (c) begin nxt = uc.tgt; sel_tgt = 1'b1; end
              else nxt = ir_entry;
      3'b110: nxt = c ? state : inc;
      3'b111: nxt = link_q;
      default: nxt = inc;
    endcase
  end

  // The timeout has priority over a normal transition, but it can only fire
  // while held (moc=0), so an arriving moc always wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= RESET_STATE;
      link_q <= '0;
    end else if (timeout) begin
      state  <= FAULT_STATE;
    end else if (!held) begin
      state <= nxt;
      if (uc.lnk && sel_tgt) link_q <= inc;
    end
  end

`ifdef MSEQ_MOC_TIMEOUT_EN
  localparam logic [7:0] CNT_MAX = 8'(TIMEOUT - 1);

  logic [7:0] wait_cnt;
  logic       fault_q;

  assign timeout   = held && (wait_cnt == CNT_MAX);
  assign mem_fault = fault_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
      fault_q  <= 1'b0;
    end else if (timeout) begin
      wait_cnt <= '0;
      fault_q  <= 1'b1;
    end else if (held) begin
      if (wait_cnt != CNT_MAX) wait_cnt <= wait_cnt + 8'd1;
    end else begin
      wait_cnt <= '0;
    end
  end

  localparam int unused_cfg = 0;
`else
  assign timeout   = 1'b0;
  assign mem_fault = 1'b0;

  // Watchdog parameters have no effect when the feature is compiled out.
  localparam int unused_cfg = int'(TIMEOUT) + int'(FAULT_STATE);
`endif

endmodule

// File: tb/tb_micro_sequencer.sv
// tb_micro_sequencer: directed self-checking bench for micro_sequencer.
// Inputs are driven 1 time unit after each rising edge, and outputs are
// checked at the same point. The watchdog section is only compiled when
// MSEQ_MOC_TIMEOUT_EN is defined.
module tb_micro_sequencer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] rom_word;
  logic [7:0]  ir_entry, cond, state, link_q;
  logic        moc, mem_wait, mem_fault;
  int          checks = 0, failures = 0;

  micro_sequencer dut (
    .clk(clk), .rst_n(rst_n), .rom_word(rom_word), .ir_entry(ir_entry),
    .cond(cond), .moc(moc), .state(state), .link_q(link_q),
    .mem_wait(mem_wait), .mem_fault(mem_fault)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL sim_timeout got=running want=finished");
    $fatal(1);
  end

  // Ignored control-word bits are set to 1 to prove they do not matter.
  function automatic logic [63:0] uw(input logic [2:0] n, input logic inv,
                                     input logic mi, input logic [2:0] s,
                                     input logic lnk, input logic [7:0] tgt);
    logic [63:0] w;
    w = '1;
    w[57:55] = n; w[54] = inv; w[53] = mi; w[52:50] = s; w[49] = lnk;
    w[41:34] = tgt;
    return w;
  endfunction

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; moc = 1'b0; ir_entry = '0; cond = 8'h01;
    rom_word = uw(3'b010, 0, 0, 0, 0, 8'd0);
    #12 rst_n = 1'b1;
    tick();
    // Move away from reset and load the link so that reset has work to undo.
    rom_word = uw(3'b011, 0, 0, 0, 1, 8'd50);
    tick();
    check("pre_rst_state", state, 50);
    check("pre_rst_link", link_q, 2);

    // Asynchronous reset in mid-cycle; mem_wait stays combinational.
    #3 rom_word = uw(3'b010, 0, 1, 0, 0, 8'd0); rst_n = 1'b0;
    #1;
    check("rst_state", state, 0);
    check("rst_link", link_q, 0);
    check("rst_fault", mem_fault, 0);
    check("rst_mem_wait", mem_wait, 1);
    rom_word = uw(3'b010, 0, 0, 0, 0, 8'd0);
    tick(); rst_n = 1'b1;
    check("fetch0", state, 0);
    tick(); check("fetch1", state, 1);
    tick(); check("fetch2", state, 2);

    // Decode dispatch
    ir_entry = 8'd27; rom_word = uw(3'b000, 0, 0, 0, 0, 8'd0);
    tick(); check("dispatch_ir", state, 27);
    ir_entry = 8'd10; cond = 8'h01;
    rom_word = uw(3'b101, 0, 0, 3'd1, 0, 8'd44);
    tick(); check("n101_false", state, 10);
    cond = 8'h03; rom_word = uw(3'b101, 0, 0, 3'd1, 0, 8'd44);
    tick(); check("n101_true", state, 44);
    rom_word = uw(3'b001, 0, 0, 0, 0, 8'd0);
    tick(); check("n001_reset", state, 0);

    // Conditional hold with an inverted condition
    rom_word = uw(3'b011, 0, 0, 0, 0, 8'd39);
    tick(); check("goto39", state, 39);
    cond = 8'h01; rom_word = uw(3'b110, 1, 0, 3'd6, 0, 8'd0);
    for (int i = 0; i < 3; i++) begin tick(); check("hold39", state, 39); end
    cond = 8'h41;
    tick(); check("hold_release", state, 40);

    // Increment wrap
    rom_word = uw(3'b011, 0, 0, 0, 0, 8'd255);
    tick(); check("goto255", state, 255);
    rom_word = uw(3'b010, 0, 0, 0, 0, 8'd0);
    tick(); check("wrap", state, 0);

    // Call and return
    rom_word = uw(3'b011, 0, 0, 0, 0, 8'd20);
    tick(); check("goto20", state, 20);
    check("link_idle", link_q, 0);
    rom_word = uw(3'b011, 0, 0, 0, 1, 8'd31);
    tick(); check("call_state", state, 31);
    check("call_link", link_q, 21);
    rom_word = uw(3'b010, 0, 0, 0, 0, 8'd0);
    tick(); check("in_sub", state, 32);
    rom_word = uw(3'b111, 0, 0, 0, 1, 8'd99);
    tick(); check("ret_state", state, 21);
    check("ret_link_kept", link_q, 21);
    // N=100 with LNK: a not-taken branch leaves link_q unchanged, a taken branch loads it
    rom_word = uw(3'b100, 0, 0, 3'd7, 1, 8'd90);
    tick(); check("br_not_taken", state, 22);
    check("br_nt_link", link_q, 21);
    rom_word = uw(3'b100, 0, 0, 3'd0, 1, 8'd90);
    tick(); check("br_taken", state, 90);
    check("br_t_link", link_q, 23);

    // MOC wait
    rom_word = uw(3'b011, 0, 0, 0, 0, 8'd3);
    tick(); check("goto3", state, 3);
    moc = 1'b0; rom_word = uw(3'b011, 0, 1, 0, 1, 8'd4);
    #1 check("wait_comb", mem_wait, 1);
    for (int i = 0; i < 5; i++) begin
      tick(); check("wait_state", state, 3); check("wait_flag", mem_wait, 1);
    end
    check("wait_link", link_q, 23);
    moc = 1'b1;
    #1 check("moc_comb", mem_wait, 0);
    tick(); check("moc_state", state, 4);
    check("moc_link", link_q, 4);
    check("no_fault", mem_fault, 0);

`ifdef MSEQ_MOC_TIMEOUT_EN
    // Watchdog fires on the 16th held edge
    moc = 1'b0; rom_word = uw(3'b010, 0, 1, 0, 0, 8'd0);
    for (int i = 0; i < 15; i++) begin
      tick(); check("to_hold", state, 4); check("to_nofault", mem_fault, 0);
    end
    tick(); check("to_state", state, 255);
    check("to_fault", mem_fault, 1);
    check("to_link", link_q, 4);
    rom_word = uw(3'b010, 0, 0, 0, 0, 8'd0);
    tick(); check("to_after", state, 0);
    check("to_sticky", mem_fault, 1);
    #2 rst_n = 1'b0; #1 check("to_rst_clear", mem_fault, 0);
    tick(); rst_n = 1'b1;
    // moc arrives on the 15th wait cycle
    moc = 1'b0; rom_word = uw(3'b011, 0, 1, 0, 0, 8'd60);
    for (int i = 0; i < 14; i++) tick();
    check("m15_hold", state, 0);
    moc = 1'b1;
    tick(); check("m15_state", state, 60);
    check("m15_fault", mem_fault, 0);
    // moc arrives when the counter is at its limit
    moc = 1'b0; rom_word = uw(3'b011, 0, 1, 0, 0, 8'd70);
    for (int i = 0; i < 15; i++) tick();
    check("m16_hold", state, 60);
    moc = 1'b1;
    tick(); check("m16_state", state, 70);
    check("m16_fault", mem_fault, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/micro_sequencer.md
# micro_sequencer

- Next-state engine of the microprogrammed control unit.
- Drives the 8-bit microstore address into the control ROM and consumes the 64-bit control word the ROM returns.
- Next-address fields of that word, the instruction-entry address and the status/condition bits together select the following microstate.
- Also handles memory-completion (MOC) waits, one-level micro-subroutine linkage and an optional MOC watchdog.

## Interface
- RESET_STATE, 8'd0, state loaded on reset.
- FAULT_STATE, 8'd255, state forced on MOC timeout (only with MSEQ_MOC_TIMEOUT_EN).
- TIMEOUT, 16, maximum consecutive MOC-wait cycles, range 2..255.
- Clock and reset: one clock, `clk`; reset `rst_n` is asynchronous and active-low.
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rom_word  in  64  current control word from the control ROM.
- ir_entry  in  8  first microstate of the decoded instruction, from the instruction encoder.
- cond  in  8  status vector:
  - [0] always-1
  - [1] instruction condition true
  - [2] Z
  - [3] N
  - [4] C
  - [5] V
  - [6] LSM count done
  - [7] always-0
- moc  in  1  memory operation complete.
- state  out  8  current microstate; drives the ROM address.
- link_q  out  8  subroutine return address.
- mem_wait  out  1  combinational; high while the current state is held for MOC.
- mem_fault  out  1  sticky timeout flag.

## Operation
- Fields decoded from rom_word:
  - N = [57:55]
  - INV = [54]
  - MI = [53] (MOC wait)
  - S = [52:50]
  - LNK = [49] (CR15)
  - TGT = [41:34] (CR7..CR0)
  - All other bits are ignored by this block.
- Condition result: c = cond[S] ^ INV.
- Next-address select by N:
  - 000: ir_entry
  - 001: RESET_STATE
  - 010: state+1
  - 011: TGT
  - 100: c ? TGT : state+1
  - 101: c ? TGT : ir_entry
  - 110: c ? state (hold) : state+1
  - 111: link_q (return)
- Increment is 8-bit and wraps: 255+1 = 0.
- Link: when LNK=1 and the selected next address is TGT, link_q <= state+1 (wrapping) on the same edge. Otherwise link_q holds.
- MOC wait (MI=1 and moc=0):
  - state and link_q hold.
  - mem_wait=1.
  - N, LNK and the condition are not evaluated.
- MI=1 with moc=1 behaves exactly as MI=0 for that cycle.
- Wait counter:
  - Increments on each held wait cycle.
  - Clears to 0 on any cycle that is not held.
  - Saturates at TIMEOUT-1 (reachable only with the timeout feature).
- Reset values: state=RESET_STATE, link_q=0, mem_fault=0, wait counter=0. mem_wait follows rom_word and moc.
- Reset mid-wait: a reset asserted during a MOC wait aborts it immediately, with no pending transition retained.

## Timing
- Address path, one cycle per microstate:
  - state is registered.
  - The ROM is combinational.
  - The next address is computed combinationally from rom_word, cond, ir_entry and moc, and loaded at the next rising edge.
- Latency: a change on ir_entry or cond affects state on the first rising edge after it is stable, with zero added cycles.
- mem_wait has no register stage; it reflects MI & ~moc of the current cycle.
- Simultaneous events:
  - moc rising in the same cycle the counter reaches TIMEOUT-1: moc wins and the normal transition occurs.
  - LNK=1 with N=111: link_q is not updated, because the target is not TGT.
- rst_n deassertion is sampled synchronously by the design's reset synchronizer upstream. This block has no extra settle cycles.

## Configuration
- MSEQ_MOC_TIMEOUT_EN defined:
  - If a MOC wait is still held when the counter equals TIMEOUT-1 and moc=0, the next edge loads FAULT_STATE.
  - That same edge sets mem_fault=1, clears the counter and leaves link_q unchanged.
  - mem_fault stays 1 until rst_n.
- MSEQ_MOC_TIMEOUT_EN undefined:
  - Waits are unbounded.
  - mem_fault is tied 0 and the counter logic is absent.

## Test plan
- Reset and fetch:
  - Assert rst_n=0 mid-cycle -> state=0, link_q=0, mem_fault=0 immediately.
  - Release with N=010 -> state steps 0,1,2 on successive edges.
- Decode dispatch: N=000, ir_entry=8'd27 -> state=27 after one edge. N=101, S=1, INV=0, cond[1]=0, ir_entry=8'd10 -> state=10. Same with cond[1]=1 and TGT=8'd44 -> state=44.
- Conditional hold:
  - N=110, S=6, INV=1, cond[6]=0 for 3 cycles, then 1, starting at state=39 -> state 39 held for 3 edges, then 40.
  - State 255 with N=010 -> 0.
- Call/return: at state=20, N=011, LNK=1, TGT=8'd31 -> state=31, link_q=21. Later N=111 -> state=21.
- MOC wait:
  - MI=1, moc=0 for 5 cycles at state=3 -> state=3, mem_wait=1 throughout.
  - moc=1 with N=011, TGT=4 -> state=4, mem_wait=0.
- Timeout (MSEQ_MOC_TIMEOUT_EN, TIMEOUT=16):
  - MI=1, moc=0 held -> state=255 and mem_fault=1 on the 16th edge.
  - moc=1 arriving on the 15th wait cycle -> normal transition, mem_fault=0.
